conv_window_sequencer: RTL
==========================

// Module: conv_window_sequencer
// PURPOSE
//  Sequences the shift_register line buffer for a KxK convolution over an IMG_LENGTH x IMG_HEIGHT frame.
//  Takes a valid/ready pixel stream and drives the buffer's reset, write_en and serial_img_in.
//  Flags each cycle where the buffer holds a legal (non-row-wrapping) window, with its row/col.
//  Stalls the pixel source while a downstream consumer has not accepted the current window.
// PARAMETERS
//  BITS        9   pixel width
//  KERNEL_SIZE 3   window edge K
//  IMG_LENGTH  16  frame width W (pixels per row)
//  IMG_HEIGHT  16  frame height H
//  PCW/CW      derived: clog2(W*H+1) pixel count width; clog2(max(W,H)) row/col width
// PORTS
//  clk             in   1     rising-edge clock
//  reset_n         in   1     synchronous active-low reset
//  start           in   1     begin a frame (sampled in IDLE only)
//  pix_in          in   BITS  source pixel
//  pix_in_valid    in   1     source pixel valid
//  pix_in_ready    out  1     sequencer accepts pix_in this cycle
//  sr_reset        out  1     active-high reset to shift_register
//  sr_write_en     out  1     shift_register write enable
//  sr_serial_img_in out BITS  pixel to shift_register (= pix_in, combinational)
//  sr_ready        in   1     shift_register ready
//  win_valid       out  1     shift_register out holds a legal window
//  win_ready       in   1     downstream accepts window
//  win_row         out  CW    top-left row of current window
//  win_col         out  CW    top-left col of current window
//  busy            out  1     high in CLEAR/FILL/STREAM
//  done            out  1     one-cycle pulse at frame end
//  err             out  1     sticky: sr_ready low when first window expected
// BEHAVIOUR
//  Reset (reset_n=0 at edge): state IDLE; counters 0; win_valid, done, err, busy = 0; sr_reset=1 while reset_n=0.
//  States: IDLE -start-> CLEAR (1 cycle, sr_reset=1, pcnt=0, err cleared) -> FILL -> STREAM -> DONE (1 cycle, done=1) -> IDLE.
//  pix_in_ready = (FILL|STREAM) & (pcnt < W*H) & (!win_valid | win_ready). Accept = pix_in_valid & pix_in_ready.
//  sr_write_en = accept (same cycle); pcnt increments on accept. No write while stalled: buffer contents hold.
//  Pixel p (0-based) accepted: win_valid registered high next cycle iff p >= W*(K-1)+K-1 and (p mod W) >= K-1.
//   win_row = p/W-(K-1), win_col = p%W-(K-1), registered with win_valid. Row-wrap positions never flagged.
//  win_valid stays high until win_ready; new accept in the same cycle as win_ready re-evaluates next cycle.
//  FILL -> STREAM on accept of p = W*(K-1)+K-1; next cycle sr_ready must be 1 else err=1 (sticky, frame continues).
//  STREAM -> DONE when pcnt = W*H and (!win_valid | win_ready). Windows per frame: (H-K+1)*(W-K+1) (196 default).
//  start outside IDLE ignored. Mid-frame reset_n=0: abort, IDLE, sr_reset=1, no done pulse.
//  pix_in_valid with pcnt = W*H: not accepted (ready=0). Counters never wrap within a frame.
// CONFIGURATION
//  SEQ_WIN_COUNT_EN defined: extra port win_count out clog2(W*H+1); counts window handshakes (win_valid&win_ready),
//   cleared in CLEAR, holds after DONE until next start.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  Reset: reset_n=0 2 cycles -> win_valid=0, busy=0, done=0, sr_reset=1; release -> IDLE, pix_in_ready=0.
//  Full frame, valid=1, win_ready=1, pix=p: first win_valid 1 cycle after p=34, row0 col0; 196 windows; done once.
//  Row wrap: pixels p=48,49 accepted -> win_valid=0; p=50 -> win_valid=1, row1 col0.
//  Backpressure: win_ready=0 for 5 cycles at row2 col3 -> pix_in_ready=0, sr_write_en=0, window/row/col stable.
//  Source gaps: pix_in_valid toggles 1/0 -> same 196 windows, same row/col order, no duplicates.
//  Abort: reset_n=0 at p=100 -> IDLE, no done; restart via start -> CLEAR pulses sr_reset, full frame passes.

Source files
------------

// File: rtl/conv_window_sequencer.sv
// Drives a KxK shift_register line buffer from a valid/ready pixel stream.
// Optional window handshake counter: define SEQ_WIN_COUNT_EN.
module conv_window_sequencer #(
   parameter int BITS        = 9,
   parameter int KERNEL_SIZE = 3,
   parameter int IMG_LENGTH  = 16,
   parameter int IMG_HEIGHT  = 16,
   localparam int PCW = $clog2(IMG_LENGTH*IMG_HEIGHT+1),
   localparam int CW  = $clog2((IMG_LENGTH > IMG_HEIGHT) ?
                               IMG_LENGTH : IMG_HEIGHT)
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic [BITS-1:0] pix_in,
   input  logic            pix_in_valid,
   output logic            pix_in_ready,
   output logic            sr_reset,
   output logic            sr_write_en,
   output logic [BITS-1:0] sr_serial_img_in,
   input  logic            sr_ready,
   output logic            win_valid,
   input  logic            win_ready,
   output logic [CW-1:0]   win_row,
   output logic [CW-1:0]   win_col,
   output logic            busy,
   output logic            done,
   output logic            err
`ifdef SEQ_WIN_COUNT_EN
   ,
   output logic [PCW-1:0]  win_count
`endif
);

   localparam logic [PCW-1:0] NPIX = PCW'(IMG_LENGTH*IMG_HEIGHT);
   localparam logic [CW-1:0]  KM1  = CW'(KERNEL_SIZE-1);
   localparam logic [CW-1:0]  WM1  = CW'(IMG_LENGTH-1);
   localparam logic [CW-1:0]  HM1  = CW'(IMG_HEIGHT-1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_FILL, S_STREAM, S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [PCW-1:0]   r_pcnt;
   logic [CW-1:0]    r_prow;
   logic [CW-1:0]    r_pcol;
   logic             r_chk;
   logic             w_ready;
   logic             w_accept;
   logic             w_legal;
   logic             w_last_fill;
   logic             w_win_free;

   always_comb begin
      w_next      = r_state;
      w_win_free  = !win_valid || win_ready;
      w_ready     = ((r_state == S_FILL) || (r_state == S_STREAM)) &&
                    (r_pcnt < NPIX) && w_win_free;
      w_accept    = pix_in_valid && w_ready;
      // Position of the pixel being accepted decides window legality
      w_legal     = (r_prow >= KM1) && (r_pcol >= KM1);
      w_last_fill = (r_prow == KM1) && (r_pcol == KM1);
      unique case (r_state)
         S_IDLE:   if (start) w_next = S_CLEAR;
         S_CLEAR:  w_next = S_FILL;
         S_FILL:   if (w_accept && w_last_fill) w_next = S_STREAM;
         S_STREAM: if (r_pcnt == NPIX && w_win_free) w_next = S_DONE;
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   assign pix_in_ready     = w_ready;
   assign sr_write_en      = w_accept;
   assign sr_serial_img_in = pix_in;
   assign sr_reset         = !reset_n || (r_state == S_CLEAR);
   assign busy             = (r_state == S_CLEAR) || (r_state == S_FILL) ||
                             (r_state == S_STREAM);
   assign done             = (r_state == S_DONE);

   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_pcnt    <= '0;
         r_prow    <= '0;
         r_pcol    <= '0;
         r_chk     <= 1'b0;
         win_valid <= 1'b0;
         win_row   <= '0;
         win_col   <= '0;
         err       <= 1'b0;
`ifdef SEQ_WIN_COUNT_EN
         win_count <= '0;
`endif
      end else begin
         r_chk <= 1'b0;
         if (r_chk && !sr_ready) err <= 1'b1;
         if (r_state == S_CLEAR) begin
            r_pcnt    <= '0;
            r_prow    <= '0;
            r_pcol    <= '0;
            win_valid <= 1'b0;
            err       <= 1'b0;
`ifdef SEQ_WIN_COUNT_EN
            win_count <= '0;
`endif
         end else begin
            if (w_accept) begin
               r_pcnt    <= r_pcnt + PCW'(1);
               win_valid <= w_legal;
               win_row   <= r_prow - KM1;
               win_col   <= r_pcol - KM1;
               if (r_pcol == WM1) begin
                  r_pcol <= '0;
                  if (r_prow != HM1) r_prow <= r_prow + CW'(1);
               end else begin
                  r_pcol <= r_pcol + CW'(1);
               end
               if (r_state == S_FILL && w_last_fill) r_chk <= 1'b1;
            end else if (win_ready) begin
               win_valid <= 1'b0;
            end
`ifdef SEQ_WIN_COUNT_EN
            if (win_valid && win_ready) win_count <= win_count + PCW'(1);
`endif
         end
      end
   end

endmodule
